// File: rtl/pulse_stretcher_queue.sv
// pulse_stretcher_queue
// Turns single-clock event strobes into clean level pulses: each trigger
// gives ON_TICKS enable ticks high followed by OFF_TICKS enable ticks low.
// Optional feature macro: PULSE_QUEUE_EN
//   defined   - triggers arriving while busy are counted and replayed in order
//   undefined - triggers arriving while busy are dropped and flagged on overflow
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | no pulse in progress, waiting for trig
// ST_ACTIVE  | out high, counting ON_TICKS enable ticks
// ST_GAP     | out low guard gap, counting OFF_TICKS enable ticks
module pulse_stretcher_queue #(
    parameter int ON_TICKS  = 4,
    parameter int OFF_TICKS = 2,
    parameter int CNT_W     = 8,
    parameter int PEND_W    = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              enable,
    input  logic              trig,
    output logic              out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_GAP    = 2'd2;

    // The window timer is a down-counter: load length-1, expire at zero.
    localparam logic [CNT_W-1:0]  ON_LAST  = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0]  OFF_LAST = CNT_W'(OFF_TICKS - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              out_q, out_d;
    logic              busy_q, busy_d;
    logic              ovf_q, ovf_d;

    logic gap_expire;
    logic take_pend;
    logic trig_direct;
    logic trig_extra;

    // Classify this clock's trigger: started/replayed directly, or surplus.
    always_comb begin
        gap_expire  = (state_q == ST_GAP) && enable && (cnt_q == '0);
        take_pend   = gap_expire && (pend_q != '0);
        trig_direct = trig && ((state_q == ST_IDLE) || (gap_expire && !take_pend));
        trig_extra  = trig && !trig_direct;
    end

    // Pulse sequencing: window and gap timing advance only on enable ticks.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = ON_LAST;
                end
            end
            ST_ACTIVE: begin
                if (enable) begin
                    if (cnt_q == '0) begin
                        state_d = ST_GAP;
                        cnt_d   = OFF_LAST;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (enable) begin
                    if (cnt_q == '0) begin
                        if (take_pend || trig) begin
                            state_d = ST_ACTIVE;
                            cnt_d   = ON_LAST;
                        end else begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pending-trigger bookkeeping and overflow flag.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = 1'b0;
`ifdef PULSE_QUEUE_EN
        case ({trig_extra, take_pend})
            2'b10: begin
                if (pend_q == PEND_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_d = pend_q + PEND_W'(1);
                end
            end
            2'b01: begin
                pend_d = pend_q - PEND_W'(1);
            end
            // 2'b11: the replayed entry is replaced by the new trigger.
            default: begin
                pend_d = pend_q;
            end
        endcase
`else
        pend_d = '0;
        ovf_d  = trig_extra;
`endif
    end

    // Outputs are registered from the next state so they change with it.
    always_comb begin
        out_d  = (state_d == ST_ACTIVE);
        busy_d = (state_d != ST_IDLE);
    end

    // State registers; clr clears everything, including the queue, at once.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out      = out_q;
    assign busy     = busy_q;
    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule
